dmem_resp: RTL and testbench

Data-memory responder for the RV32I core: the slave end of the load/store request the core's decoder raises with mem_en/mem_write and funct3. Holds a word-addressed RAM and accepts one request at a time with a ready handshake and a configurable wait-state count. Performs byte-lane writes and sign/zero-extended reads, and flags invalid or misaligned accesses.

---
 rtl/dmem_resp.sv | 236 +++++++++++++++++++++++
 tb/tb_dmem_resp.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// dmem_resp: word-addressed data RAM serving RV32I load/store requests with a ready
// strobe after WAIT_CYCLES wait states. Build option: DMEM_MISALIGN_TRAP_EN.
module dmem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BW = AW + 2;
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic funct3_invalid(input logic wr, input logic [2:0] f3);
    logic bad;
    case (f3)
      3'b000, 3'b001, 3'b010: bad = 1'b0;
      3'b100, 3'b101:         bad = wr;
      default:                bad = 1'b1;
    endcase
    return bad;
  endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (f3)
      3'b001, 3'b101: mis = a[0];
      3'b010:         mis = (a != 2'b00);
      default:        mis = 1'b0;
    endcase
    return mis;
  endfunction
`endif

  // Lanes are filled by replicating the store data, so only the enables pick the lane.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] a);
    logic [3:0]  be;
    logic [31:0] wide;
    logic [31:0] res;
    case (f3)
      3'b000: begin
        be   = 4'b0001 << a;
        wide = {4{wd[7:0]}};
      end
      3'b001: begin
        be   = a[1] ? 4'b1100 : 4'b0011;
        wide = {2{wd[15:0]}};
      end
      3'b010: begin
        be   = 4'b1111;
        wide = wd;
      end
      default: begin
        be   = 4'b0000;
        wide = wd;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? wide[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (a)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'd0, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'd0, h};
      3'b010:  res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  state_t        state_r;
  state_t        state_s;
  logic [3:0]    wait_cnt_r;
  logic          req_write_r;
  logic [2:0]    req_funct3_r;
  logic [BW-1:0] req_addr_r;
  logic [31:0]   req_wdata_r;
  logic          ready_r;
  logic          fault_r;
  logic [31:0]   rdata_r;
  logic [31:0]   mem_r [DEPTH_WORDS];

  logic          cur_write_s;
  logic [2:0]    cur_funct3_s;
  logic [BW-1:0] cur_addr_s;
  logic [31:0]   cur_wdata_s;
  logic [AW-1:0] word_idx_s;
  logic [31:0]   mem_word_s;
  logic          fault_s;
  logic          commit_s;
  logic          addr_unused_s;

  assign addr_unused_s = ^addr[31:BW];

  // Next-state logic for the IDLE/WAIT/RESP handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_en) begin
          state_s = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so use the live request.
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_write_s  = mem_write;
      cur_funct3_s = funct3;
      cur_addr_s   = addr[BW-1:0];
      cur_wdata_s  = wdata;
    end else begin
      cur_write_s  = req_write_r;
      cur_funct3_s = req_funct3_r;
      cur_addr_s   = req_addr_r;
      cur_wdata_s  = req_wdata_r;
    end
  end

  assign word_idx_s = cur_addr_s[BW-1:2];
  assign mem_word_s = mem_r[word_idx_s];
  assign commit_s   = (state_r != ST_RESP) && (state_s == ST_RESP) && !rst;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault_s = funct3_invalid(cur_write_s, cur_funct3_s) ||
                   misaligned(cur_funct3_s, cur_addr_s[1:0]);
`else
  assign fault_s = funct3_invalid(cur_write_s, cur_funct3_s);
`endif

  // State register and wait-state counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_WAIT) && (state_s == ST_WAIT)) begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end else begin
        wait_cnt_r <= 4'd0;
      end
    end
  end

  // Request capture; only sampled while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_write_r  <= 1'b0;
      req_funct3_r <= 3'd0;
      req_addr_r   <= '0;
      req_wdata_r  <= 32'd0;
    end else if ((state_r == ST_IDLE) && mem_en) begin
      req_write_r  <= mem_write;
      req_funct3_r <= funct3;
      req_addr_r   <= addr[BW-1:0];
      req_wdata_r  <= wdata;
    end
  end

  // Registered response: one-cycle strobe, rdata/fault cleared outside RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b0;
      fault_r <= 1'b0;
      rdata_r <= 32'd0;
    end else if (commit_s) begin
      ready_r <= 1'b1;
      fault_r <= fault_s;
      rdata_r <= (fault_s || cur_write_s) ? 32'd0 :
                 load_extract(mem_word_s, cur_funct3_s, cur_addr_s[1:0]);
    end else begin
      ready_r <= 1'b0;
      fault_r <= 1'b0;
      rdata_r <= 32'd0;
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (commit_s && cur_write_s && !fault_s) begin
      mem_r[word_idx_s] <= store_merge(mem_word_s, cur_wdata_s, cur_funct3_s, cur_addr_s[1:0]);
    end
  end

  assign ready = ready_r;
  assign fault = fault_r;
  assign rdata = rdata_r;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed testbench for dmem_resp: instance A (1024 words, 1 wait state) and
// instance B (16 words, 2 wait states) for latency, aliasing and mid-request reset.
module tb_dmem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        rst_a, en_a, wr_a, rdy_a, flt_a;
  logic [2:0]  f3_a;
  logic [31:0] addr_a, wd_a, rd_a;
  logic        rst_b, en_b, wr_b, rdy_b, flt_b;
  logic [2:0]  f3_b;
  logic [31:0] addr_b, wd_b, rd_b;

  dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .mem_en(en_a), .mem_write(wr_a), .funct3(f3_a),
    .addr(addr_a), .wdata(wd_a), .rdata(rd_a), .ready(rdy_a), .fault(flt_a)
  );

  dmem_resp #(.DEPTH_WORDS(16), .WAIT_CYCLES(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .mem_en(en_b), .mem_write(wr_b), .funct3(f3_b),
    .addr(addr_b), .wdata(wd_b), .rdata(rd_b), .ready(rdy_b), .fault(flt_b)
  );

  // Drives one request and returns the response; lat is the cycle (1 = right after
  // the accepting edge) in which ready was seen, -1 if never. post = {ready,fault,rdata}
  // one cycle after the response.
  task automatic do_req(input bit sel, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic flt, output int lat,
                        output int acc, output logic [33:0] post);
    logic seen;
    @(negedge clk);
    if (sel) begin
      en_b = 1'b1; wr_b = wr; f3_b = f3; addr_b = a; wd_b = wd;
    end else begin
      en_a = 1'b1; wr_a = wr; f3_a = f3; addr_a = a; wd_a = wd;
    end
    @(posedge clk); #1;
    acc  = cyc;
    lat  = 1;
    seen = sel ? rdy_b : rdy_a;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      seen = sel ? rdy_b : rdy_a;
    end
    rd  = sel ? rd_b : rd_a;
    flt = sel ? flt_b : flt_a;
    if (!seen) lat = -1;
    if (sel) en_b = 1'b0; else en_a = 1'b0;
    @(posedge clk); #1;
    post = sel ? {rdy_b, flt_b, rd_b} : {rdy_a, flt_a, rd_a};
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    en_a = 1'b0; wr_a = 1'b0; f3_a = 3'd0; addr_a = 32'd0; wd_a = 32'd0;
    en_b = 1'b0; wr_b = 1'b0; f3_b = 3'd0; addr_b = 32'd0; wd_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({rdy_a, flt_a, rd_a} !== 34'd0) begin errors++; $display("FAIL reset_a: got %h expected 0", {rdy_a, flt_a, rd_a}); end
    checks++; if ({rdy_b, flt_b, rd_b} !== 34'd0) begin errors++; $display("FAIL reset_b: got %h expected 0", {rdy_b, flt_b, rd_b}); end
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b expected 0", rdy_a); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic flt; int lat, acc; logic [33:0] post;
    do_req(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, flt, lat, acc, post);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    checks++; if (flt !== 1'b0) begin errors++; $display("FAIL sw_fault: got %b expected 0", flt); end
    do_req(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, rd, flt, lat, acc, post);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", rd); end
    checks++; if (flt !== 1'b0) begin errors++; $display("FAIL lw_fault: got %b expected 0", flt); end
    checks++; if (post !== 34'd0) begin errors++; $display("FAIL lw_post: got %h expected 0", post); end
    do_req(1'b0, 1'b0, 3'b010, 32'h1010, 32'h0, rd, flt, lat, acc, post);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL alias_a: got %h expected deadbeef", rd); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic flt; int lat, acc; logic [33:0] post;
    do_req(1'b0, 1'b1, 3'b010, 32'h20, 32'h00000000, rd, flt, lat, acc, post);
    do_req(1'b0, 1'b1, 3'b000, 32'h21, 32'h000000AB, rd, flt, lat, acc, post);
    do_req(1'b0, 1'b1, 3'b001, 32'h22, 32'h00001234, rd, flt, lat, acc, post);
    do_req(1'b0, 1'b0, 3'b010, 32'h20, 32'h0, rd, flt, lat, acc, post);
    checks++; if (rd !== 32'h1234AB00) begin errors++; $display("FAIL byte_lanes: got %h expected 1234ab00", rd); end
  endtask

  task automatic test_load_ext();
    logic [31:0] rd; logic flt; int lat, acc; logic [33:0] post;
    logic [31:0] la [7] = '{32'h30, 32'h30, 32'h32, 32'h32, 32'h33, 32'h31, 32'h30};
    logic [2:0]  lf [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b100, 3'b101};
    logic [31:0] le [7] = '{32'hFFFFFF81, 32'h00000081, 32'hFFFF80FF, 32'h000080FF,
                            32'hFFFFFF80, 32'h0000007F, 32'h00007F81};
    do_req(1'b0, 1'b1, 3'b010, 32'h30, 32'h80FF7F81, rd, flt, lat, acc, post);
    for (int i = 0; i < 7; i++) begin
      do_req(1'b0, 1'b0, lf[i], la[i], 32'h0, rd, flt, lat, acc, post);
      checks++;
      if (rd !== le[i] || flt !== 1'b0) begin
        errors++;
        $display("FAIL load_ext[%0d]: got %h/%b expected %h/0", i, rd, flt, le[i]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [31:0] rd; logic flt; int lat, acc; logic [33:0] post;
    logic       iw [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] if3 [6] = '{3'b011, 3'b110, 3'b111, 3'b100, 3'b101, 3'b011};
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, iw[i], if3[i], 32'h30, 32'h00000000, rd, flt, lat, acc, post);
      checks++;
      if (lat !== 2 || flt !== 1'b1 || rd !== 32'd0) begin
        errors++;
        $display("FAIL invalid[%0d]: got lat=%0d fault=%b rdata=%h expected lat=2 fault=1 rdata=0",
                 i, lat, flt, rd);
      end
    end
    do_req(1'b0, 1'b0, 3'b010, 32'h30, 32'h0, rd, flt, lat, acc, post);
    checks++; if (rd !== 32'h80FF7F81) begin errors++; $display("FAIL invalid_nowrite: got %h expected 80ff7f81", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic flt; int lat, acc; logic [33:0] post;
    do_req(1'b0, 1'b0, 3'b010, 32'h13, 32'h0, rd, flt, lat, acc, post);
    checks++; if ({flt, rd} !== (TRAP ? 33'h1_00000000 : 33'h0_DEADBEEF)) begin errors++; $display("FAIL mis_lw: got %b/%h expected trap=%b", flt, rd, TRAP); end
    do_req(1'b0, 1'b0, 3'b001, 32'h31, 32'h0, rd, flt, lat, acc, post);
    checks++; if ({flt, rd} !== (TRAP ? 33'h1_00000000 : 33'h0_00007F81)) begin errors++; $display("FAIL mis_lh: got %b/%h expected trap=%b", flt, rd, TRAP); end
    do_req(1'b0, 1'b1, 3'b010, 32'h31, 32'h12345678, rd, flt, lat, acc, post);
    checks++; if (flt !== TRAP) begin errors++; $display("FAIL mis_sw_fault: got %b expected %b", flt, TRAP); end
    do_req(1'b0, 1'b0, 3'b010, 32'h30, 32'h0, rd, flt, lat, acc, post);
    checks++; if (rd !== (TRAP ? 32'h80FF7F81 : 32'h12345678)) begin errors++; $display("FAIL mis_sw_word: got %h expected trap=%b", rd, TRAP); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic flt; int lat, acc0, acc1, acc2; logic [33:0] post;
    do_req(1'b0, 1'b0, 3'b010, 32'h20, 32'h0, rd, flt, lat, acc0, post);
    do_req(1'b0, 1'b0, 3'b010, 32'h20, 32'h0, rd, flt, lat, acc1, post);
    do_req(1'b0, 1'b0, 3'b010, 32'h20, 32'h0, rd, flt, lat, acc2, post);
    checks++; if (acc1 - acc0 !== 3 || acc2 - acc1 !== 3) begin errors++; $display("FAIL throughput_a: got %0d,%0d expected 3,3", acc1 - acc0, acc2 - acc1); end
    checks++; if (post !== 34'd0) begin errors++; $display("FAIL post_a: got %h expected 0", post); end
    do_req(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, rd, flt, lat, acc0, post);
    do_req(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, rd, flt, lat, acc1, post);
    checks++; if (acc1 - acc0 !== 4) begin errors++; $display("FAIL throughput_b: got %0d expected 4", acc1 - acc0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic flt; int lat, acc; logic [33:0] post;
    int pulses;
    do_req(1'b1, 1'b1, 3'b010, 32'h40, 32'h22222222, rd, flt, lat, acc, post);
    checks++; if (lat !== 3) begin errors++; $display("FAIL b_sw_latency: got %0d expected 3", lat); end
    @(negedge clk);
    en_b = 1'b1; wr_b = 1'b1; f3_b = 3'b010; addr_b = 32'h40; wd_b = 32'h11111111;
    @(posedge clk); #2;
    rst_b = 1'b1;
    en_b  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rdy_b) pulses++;
    end
    @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (rdy_b) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_mid_ready: got %0d pulses expected 0", pulses); end
    do_req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, rd, flt, lat, acc, post);
    checks++; if (rd !== 32'h22222222) begin errors++; $display("FAIL reset_mid_word: got %h expected 22222222", rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL b_lw_latency: got %0d expected 3", lat); end
    do_req(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, rd, flt, lat, acc, post);
    checks++; if (rd !== 32'h22222222) begin errors++; $display("FAIL alias_b: got %h expected 22222222", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_load_ext();
    test_invalid();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
